// File: rtl/arm_decode_queue.sv
// arm_decode_queue: one-stage ARM instruction decoder feeding a DEPTH-entry FIFO.
// S1 captures the instruction and flags; decode and condition evaluation are combinational
// on S1, and the result is pushed into a first-word-visible FIFO.
module arm_decode_queue #(
  parameter int unsigned CODE_W     = 6,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned UNDEF_CODE = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [3:0]        in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_exec,
  output logic              out_undef,
  output logic [31:0]       out_instr,
  output logic [15:0]       undef_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [CODE_W-1:0] code_t;
  localparam code_t Undef = code_t'(UNDEF_CODE);

  function automatic code_t c(input int unsigned v);
    return code_t'(v);
  endfunction

  // Standard ARM condition evaluation; flags are {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cy;
      4'h3:    return !cy;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cy && !z;
      4'h9:    return !cy || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic          s1_valid_q, s1_valid_d;
  logic [31:0]   s1_instr_q, s1_instr_d;
  logic [3:0]    s1_flags_q, s1_flags_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   undef_cnt_q, undef_cnt_d;

  code_t       code_mem  [DEPTH];
  logic        exec_mem  [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  code_t dec_code;
  logic  dec_exec;
  logic  push, pop, push_en, pop_en, accept;

  // Decode the S1 instruction into a control-unit state code.
  always_comb begin
    logic p, w, l, b4, b7;
    p = s1_instr_q[24];
    w = s1_instr_q[21];
    l = s1_instr_q[20];
    b4 = s1_instr_q[4];
    b7 = s1_instr_q[7];
    dec_code = Undef;
    if (s1_instr_q == 32'd0) begin
      dec_code = c(0);
    end else begin
      case (s1_instr_q[27:25])
        3'b000: begin
          if (!b4)       dec_code = (s1_instr_q[11:7] == 5'd0) ? c(5) : c(7);
          else if (!b7) dec_code = c(8);
          else if (!p)  dec_code = l ? c(41) : c(37);
          else if (!w)  dec_code = l ? c(39) : c(35);
          else          dec_code = l ? c(40) : c(36);
        end
        3'b001: dec_code = c(6);
        3'b010: begin
          if (!p)       dec_code = l ? c(24) : c(16);
          else if (!w)  dec_code = l ? c(20) : c(12);
          else          dec_code = l ? c(22) : c(14);
        end
        3'b011: begin
          if (b4)       dec_code = Undef;
          else if (!p)  dec_code = l ? c(26) : c(18);
          else if (!w)  dec_code = l ? c(21) : c(13);
          else          dec_code = l ? c(23) : c(15);
        end
        3'b100:  dec_code = l ? c(46) : c(45);
        3'b101:  dec_code = p ? c(44) : c(43);
        3'b110:  dec_code = Undef;
        default: dec_code = p ? c(47) : Undef;
      endcase
    end
    // An all-zero word is a bubble and never executes.
    dec_exec = (s1_instr_q != 32'd0) && cond_pass(s1_instr_q[31:28], s1_flags_q);
  end

  // Handshake: S1 may hand off while the FIFO pops, sustaining one per cycle.
  always_comb begin
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    push      = s1_valid_q && ((count_q < CW'(DEPTH)) || pop);
    in_ready  = !s1_valid_q || push;
    accept    = in_valid && in_ready && !flush;
    push_en   = push && !flush;
    pop_en    = pop && !flush;
  end

  // Next-state for S1, pointers, occupancy and the undefined counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_instr_d  = s1_instr_q;
    s1_flags_d  = s1_flags_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    undef_cnt_d = undef_cnt_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_instr_d = in_instr;
        s1_flags_d = in_flags;
      end else if (push) begin
        s1_valid_d = 1'b0;
      end
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_en && (dec_code == Undef) && (undef_cnt_q != 16'hFFFF)) begin
        undef_cnt_d = undef_cnt_q + 16'd1;
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_instr_q  <= '0;
      s1_flags_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      undef_cnt_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_instr_q  <= s1_instr_d;
      s1_flags_q  <= s1_flags_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      undef_cnt_q <= undef_cnt_d;
    end
  end

  // FIFO storage; stale contents are masked by the empty check on the outputs.
  always_ff @(posedge clk) begin
    if (push_en) begin
      code_mem[wr_ptr_q]  <= dec_code;
      exec_mem[wr_ptr_q]  <= dec_exec;
      instr_mem[wr_ptr_q] <= s1_instr_q;
    end
  end

  // Head presented combinationally, forced to zero when empty.
  always_comb begin
    out_code    = out_valid ? code_mem[rd_ptr_q] : '0;
    out_exec    = out_valid ? exec_mem[rd_ptr_q] : 1'b0;
    out_instr   = out_valid ? instr_mem[rd_ptr_q] : 32'd0;
    out_undef   = out_valid && (code_mem[rd_ptr_q] == Undef);
    undef_count = undef_cnt_q;
  end

endmodule

// File: tb/tb_arm_decode_queue.sv
// Scoreboard bench for arm_decode_queue: the driver queues expected results on accept,
// a monitor pops and compares on every output handshake.
module tb_arm_decode_queue;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_exec, out_undef;
  logic [31:0] in_instr, out_instr;
  logic [3:0]  in_flags;
  logic [5:0]  out_code;
  logic [15:0] undef_count;

  arm_decode_queue #(.CODE_W(6), .DEPTH(4), .UNDEF_CODE(63)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_exec(out_exec), .out_undef(out_undef), .out_instr(out_instr),
    .undef_count(undef_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  code;
    logic        exec;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: sample mid-low-phase, ahead of the edge that completes the pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: got instr %h expected nothing", out_instr);
        end else begin
          e = sb.pop_front();
          if (out_code !== e.code || out_exec !== e.exec || out_instr !== e.instr ||
              out_undef !== (e.code == 6'd63)) begin
            miscompares++;
            $display("FAIL head %h: got code %0d exec %b undef %b instr %h expected code %0d exec %b",
                     e.instr, out_code, out_exec, out_undef, out_instr, e.code, e.exec);
          end
        end
      end
    end
  end

  // Offer one word from a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [3:0] fl, input logic [5:0] code,
                      input logic ex);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_flags = fl;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      sb.push_back('{code: code, exec: ex, instr: ins});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain_left", sb.size(), 0);
  endtask

  logic [31:0] bp_instr [5] = '{32'hE5812004, 32'hE4912004, 32'hE1D120B4,
                                32'hE7912003, 32'hE0000090};
  logic [5:0]  bp_code  [5] = '{6'd12, 6'd24, 6'd39, 6'd21, 6'd37};

  initial begin
    time t0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_flags = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_code", out_code, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_undef_count", undef_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single LDR: P=1, W=0, L=1 decodes to 20; head appears one cycle after accept.
    out_ready = 1'b1;
    send(32'hE5912004, 4'h0, 6'd20, 1'b1);
    #1 check("lat_not_yet", out_valid, 0);
    @(negedge clk);
    #1 check("lat_head_valid", out_valid, 1);
    check("lat_head_code", out_code, 20);
    check("lat_undef_count", undef_count, 0);
    @(negedge clk);

    // Back-to-back stream at one per cycle.
    t0 = $time;
    send(32'hE3A01005, 4'h0, 6'd6, 1'b1);
    send(32'hE1A00001, 4'h0, 6'd5, 1'b1);
    send(32'hEB000010, 4'h0, 6'd44, 1'b1);
    send(32'h00000000, 4'h0, 6'd0, 1'b0);
    check("stream_cycles", 32'(($time - t0) / 10), 4);

    // Condition codes.
    send(32'h0A000004, 4'b0100, 6'd43, 1'b1);
    send(32'h0A000004, 4'b0000, 6'd43, 1'b0);
    send(32'hF5912004, 4'b1111, 6'd20, 1'b0);
    send(32'hCA000000, 4'b0000, 6'd43, 1'b1);
    send(32'h8A000000, 4'b0010, 6'd43, 1'b1);
    send(32'hBA000000, 4'b1000, 6'd43, 1'b1);
    send(32'hBA000000, 4'b1001, 6'd43, 1'b0);
    send(32'hEF000000, 4'h0, 6'd47, 1'b1);
    send(32'hE1A00081, 4'h0, 6'd7, 1'b1);
    drain();

    // Backpressure: four in the FIFO, one held in S1, sixth refused.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(bp_instr[i], 4'h0, bp_code[i], 1'b1);
    in_valid = 1'b1;
    in_instr = 32'hE0000010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_head_instr", out_instr, bp_instr[0]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(32'hE0000010, 4'h0, 6'd8, 1'b1);
    drain();

    // Undefined encodings, then a flush with an offer pending.
    out_ready = 1'b0;
    send(32'hE6100010, 4'h0, 6'd63, 1'b1);
    send(32'hEC000000, 4'h0, 6'd63, 1'b1);
    @(negedge clk);
    #1;
    check("undef_head_code", out_code, 63);
    check("undef_head_flag", out_undef, 1);
    check("undef_count_2", undef_count, 2);
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hE3A01005;
    sb.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_undef_count", undef_count, 2);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("flush_no_capture", out_valid, 0);

    // Fill to full, then async reset between edges.
    out_ready = 1'b0;
    send(32'hEE000000, 4'h0, 6'd63, 1'b1);
    for (int i = 1; i < 5; i++) send(bp_instr[i], 4'h0, bp_code[i], 1'b1);
    #1;
    check("full_in_ready", in_ready, 0);
    check("full_undef_count", undef_count, 3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    sb.delete();
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_code", out_code, 0);
    check("arst_out_exec", out_exec, 0);
    check("arst_out_undef", out_undef, 0);
    check("arst_out_instr", out_instr, 0);
    check("arst_undef_count", undef_count, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    send(32'hE0000010, 4'h0, 6'd8, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
